// File: rtl/panel_pkg.sv
// Shared definitions for the panel input slice: command FSM states, the
// default debounce length and the switch bank field positions.
package panel_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } cmd_state_t;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

   localparam int OPERAND_MSB = 15;
   localparam int OPERAND_LSB = 8;
   localparam int OP_MSB      = 3;
   localparam int OP_LSB      = 0;

endpackage

// File: rtl/panel_input_debouncer.sv
// Single-button debouncer: 2-flop synchronizer, consecutive-difference
// counter, stable level and a one-cycle press strobe on a 0->1 stable flip.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   btn_raw       unsynchronized button level
//   press         one-cycle strobe per debounced press (release is silent)
module debouncer
   import panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic          stable_q;
   logic          press_q;
   logic [CW-1:0] cnt_q;

   // The counter never exceeds DEBOUNCE_CYCLES-1: it clears on the flip.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1  <= 1'b0;
         sync_q2  <= 1'b0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
         press_q <= 1'b0;
         if (sync_q2 == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync_q2;
            cnt_q    <= '0;
            press_q  <= sync_q2;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign press = press_q;

endmodule

// File: rtl/panel_input.sv
// Front-panel input block: debounces the execute (btnC) and clear (btnU)
// buttons, synchronizes the switch bank and holds one pending command for a
// downstream controller with a valid/ready handshake.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   btn_c_raw, btn_u_raw    raw execute / clear buttons
//   sw_raw[15:0]            raw switches: [15:8] operand, [3:0] op
//   cmd_ready               controller accepts the pending command
//   cmd_valid               command pending
//   cmd_operand, cmd_op     captured command fields
//   clear_pulse             one-cycle strobe per clear press
//   overrun                 sticky: an execute press was dropped
module panel_input
   import panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        btn_c_raw,
   input  logic        btn_u_raw,
   input  logic [15:0] sw_raw,
   input  logic        cmd_ready,
   output logic        cmd_valid,
   output logic [7:0]  cmd_operand,
   output logic [3:0]  cmd_op,
   output logic        clear_pulse,
   output logic        overrun
);

   logic       exec_evt;
   logic       clr_evt;
   logic [7:0] operand_s1, operand_s2;
   logic [3:0] op_s1, op_s2;
   logic       unused_sw_bits;

   cmd_state_t state_q, state_d;
   logic [7:0] operand_q, operand_d;
   logic [3:0] op_q, op_d;
   logic       overrun_q, overrun_d;
   logic       clear_q, clear_d;

   assign unused_sw_bits = ^sw_raw[7:4];

   debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_c_raw),
      .press   (exec_evt)
   );

   debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_u (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_u_raw),
      .press   (clr_evt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         operand_s1 <= '0;
         operand_s2 <= '0;
         op_s1      <= '0;
         op_s2      <= '0;
      end else begin
         operand_s1 <= sw_raw[OPERAND_MSB:OPERAND_LSB];
         operand_s2 <= operand_s1;
         op_s1      <= sw_raw[OP_MSB:OP_LSB];
         op_s2      <= op_s1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         operand_q <= '0;
         op_q      <= '0;
         overrun_q <= 1'b0;
         clear_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         operand_q <= operand_d;
         op_q      <= op_d;
         overrun_q <= overrun_d;
         clear_q   <= clear_d;
      end
   end

   // Clear has priority over everything, including a coincident execute.
   always_comb begin
      state_d   = state_q;
      operand_d = operand_q;
      op_d      = op_q;
      overrun_d = overrun_q;
      clear_d   = 1'b0;
      if (clr_evt) begin
         state_d   = IDLE;
         operand_d = '0;
         op_d      = '0;
         overrun_d = 1'b0;
         clear_d   = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (exec_evt) begin
                  operand_d = operand_s2;
                  op_d      = op_s2;
                  state_d   = PENDING;
               end
            end
            PENDING: begin
               if (cmd_ready) begin
                  if (exec_evt) begin
                     operand_d = operand_s2;
                     op_d      = op_s2;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (exec_evt) begin
                  overrun_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign cmd_valid   = (state_q == PENDING);
   assign cmd_operand = operand_q;
   assign cmd_op      = op_q;
   assign clear_pulse = clear_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_panel_input.sv
module tb_panel_input;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        btn_c_raw;
   logic        btn_u_raw;
   logic [15:0] sw_raw;
   logic        cmd_ready;
   logic        cmd_valid;
   logic [7:0]  cmd_operand;
   logic [3:0]  cmd_op;
   logic        clear_pulse;
   logic        overrun;

   int total  = 0;
   int passed = 0;
   int cyc    = 0;

   typedef struct {
      bit         is_clr;
      logic [7:0] operand;
      logic [3:0] op;
      int         at;
   } exp_t;

   exp_t exp_q[$];

   panel_input #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_c_raw   (btn_c_raw),
      .btn_u_raw   (btn_u_raw),
      .sw_raw      (sw_raw),
      .cmd_ready   (cmd_ready),
      .cmd_valid   (cmd_valid),
      .cmd_operand (cmd_operand),
      .cmd_op      (cmd_op),
      .clear_pulse (clear_pulse),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endfunction

   function automatic void push(input bit is_clr, input logic [7:0] o, input logic [3:0] p, input int at);
      exp_t e;
      e.is_clr = is_clr; e.operand = o; e.op = p; e.at = at;
      exp_q.push_back(e);
   endfunction

   function automatic void check_event(input bit is_clr);
      exp_t e;
      if (exp_q.size() == 0) begin
         total++;
         $display("FAIL unexpected_event: got %s at cycle %0d expected none", is_clr ? "clear" : "cmd", cyc);
         return;
      end
      e = exp_q.pop_front();
      chk("ev_kind",    32'(is_clr),      32'(e.is_clr));
      chk("ev_cycle",   32'(cyc),         32'(e.at));
      chk("ev_operand", 32'(cmd_operand), 32'(e.operand));
      chk("ev_op",      32'(cmd_op),      32'(e.op));
      chk("ev_valid",   32'(cmd_valid),   32'(!e.is_clr));
      chk("ev_overrun", 32'(overrun),     32'(0));
   endfunction

   // Monitor: a new command shows up as a cmd_valid rise or a data change
   // while valid; a clear shows up as clear_pulse.
   logic       pv = 1'b0;
   logic [7:0] po = '0;
   logic [3:0] pp = '0;
   always @(negedge clk) begin
      if (clear_pulse) check_event(1'b1);
      if (cmd_valid && (!pv || cmd_operand != po || cmd_op != pp)) check_event(1'b0);
      if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
         total++;
         $display("FAIL event_timeout: got nothing by cycle %0d expected event at %0d", cyc, exp_q[0].at);
         void'(exp_q.pop_front());
      end
      pv = cmd_valid;
      po = cmd_operand;
      pp = cmd_op;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int c;
      reset_n = 1'b0; btn_c_raw = 1'b0; btn_u_raw = 1'b0;
      sw_raw = '0; cmd_ready = 1'b0;
      tick(2);
      chk("rst_valid",   32'(cmd_valid),   0);
      chk("rst_operand", 32'(cmd_operand), 0);
      chk("rst_op",      32'(cmd_op),      0);
      chk("rst_clear",   32'(clear_pulse), 0);
      chk("rst_overrun", 32'(overrun),     0);
      reset_n = 1'b1;
      tick(2);

      // Basic capture, held until handshake
      sw_raw = 16'hA503; tick(3);
      c = cyc; btn_c_raw = 1'b1; push(0, 8'hA5, 4'h3, c + 7);
      tick(20); btn_c_raw = 1'b0;
      chk("A_hold_valid",   32'(cmd_valid),   1);
      chk("A_hold_operand", 32'(cmd_operand), 32'hA5);
      tick(10);
      cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
      chk("A_handshake_idle", 32'(cmd_valid), 0);
      tick(3);

      // Glitch train: 3 high / 3 low never qualifies
      for (int i = 0; i < 4; i++) begin
         btn_c_raw = 1'b1; tick(3);
         btn_c_raw = 1'b0; tick(3);
      end
      tick(10);
      chk("B_no_cmd", 32'(cmd_valid), 0);

      // Overrun, switch change while pending, then clear
      sw_raw = 16'h3C05; tick(3);
      c = cyc; btn_c_raw = 1'b1; push(0, 8'h3C, 4'h5, c + 7);
      tick(10); btn_c_raw = 1'b0; tick(10);
      sw_raw = 16'h7709; tick(5);
      btn_c_raw = 1'b1; tick(10);
      chk("C_overrun",  32'(overrun),     1);
      chk("C_operand",  32'(cmd_operand), 32'h3C);
      chk("C_op",       32'(cmd_op),      32'h5);
      chk("C_valid",    32'(cmd_valid),   1);
      btn_c_raw = 1'b0; tick(10);
      c = cyc; btn_u_raw = 1'b1; push(1, 8'h00, 4'h0, c + 7);
      tick(10); btn_u_raw = 1'b0; tick(10);
      chk("C_overrun_cleared", 32'(overrun), 0);

      // Clear and execute together: clear wins
      sw_raw = 16'h5A06; tick(3);
      c = cyc; btn_c_raw = 1'b1; btn_u_raw = 1'b1; push(1, 8'h00, 4'h0, c + 7);
      tick(10); btn_c_raw = 1'b0; btn_u_raw = 1'b0; tick(10);
      chk("D_valid",   32'(cmd_valid), 0);
      chk("D_overrun", 32'(overrun),   0);

      // New press on the handshake cycle
      sw_raw = 16'h2211; tick(3);
      c = cyc; btn_c_raw = 1'b1; push(0, 8'h22, 4'h1, c + 7);
      tick(10); btn_c_raw = 1'b0; tick(10);
      sw_raw = 16'h1F07; tick(3);
      c = cyc; btn_c_raw = 1'b1; push(0, 8'h1F, 4'h7, c + 7);
      tick(6); cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
      tick(2);
      chk("E_valid",   32'(cmd_valid),   1);
      chk("E_operand", 32'(cmd_operand), 32'h1F);
      chk("E_op",      32'(cmd_op),      32'h7);
      chk("E_overrun", 32'(overrun),     0);
      tick(8); btn_c_raw = 1'b0; tick(10);
      cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
      tick(3);

      // Reset while pending with the button held
      sw_raw = 16'h4B0A; tick(3);
      c = cyc; btn_c_raw = 1'b1; push(0, 8'h4B, 4'hA, c + 7);
      tick(12);
      reset_n = 1'b0; #1;
      chk("F_rst_valid",   32'(cmd_valid),   0);
      chk("F_rst_operand", 32'(cmd_operand), 0);
      chk("F_rst_op",      32'(cmd_op),      0);
      chk("F_rst_overrun", 32'(overrun),     0);
      chk("F_rst_clear",   32'(clear_pulse), 0);
      tick(3);
      reset_n = 1'b1;
      c = cyc; push(0, 8'h4B, 4'hA, c + 7);
      tick(20); btn_c_raw = 1'b0; tick(12);

      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/panel_input.md
PANEL_INPUT -- requirements
Module: panel_input

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 250000, the number of consecutive clk cycles a synchronized button level must differ from its stable state before the stable state flips (minimum 2).
REQ-002 clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 btn_c_raw  input  1  unsynchronized execute button (btnC).
REQ-005 btn_u_raw  input  1  unsynchronized clear button (btnU).
REQ-006 sw_raw  input  16  unsynchronized switches; [15:8] operand, [3:0] operation, [7:4] ignored.
REQ-007 cmd_ready  input  1  controller accepts the pending command.
REQ-008 cmd_valid  output  1  a captured command is pending.
REQ-009 cmd_operand  output  8  operand captured from sw[15:8].
REQ-010 cmd_op  output  4  operation code captured from sw[3:0].
REQ-011 clear_pulse  output  1  one-cycle strobe per debounced btnU press.
REQ-012 overrun  output  1  sticky flag: an execute press was dropped.

Function
REQ-013 btn_c_raw, btn_u_raw and sw_raw SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 Per button: counter resets to 0 whenever the synced level equals the stable level, otherwise increments; when the counter reaches DEBOUNCE_CYCLES-1 the stable level flips and the counter clears.
REQ-015 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the stable level.
REQ-016 A press event SHALL be a 0->1 transition of the stable level; release transitions SHALL produce nothing.
REQ-017 Press-event latency: a clean raw rising edge SHALL produce its event (and any clear_pulse) exactly DEBOUNCE_CYCLES+3 cycles later.
REQ-018 Command FSM states: IDLE (cmd_valid=0), PENDING (cmd_valid=1).
REQ-019 IDLE + execute event: the synced sw[15:8] and sw[3:0] of that same cycle SHALL be registered into cmd_operand/cmd_op; next state PENDING.
REQ-020 PENDING: cmd_operand/cmd_op SHALL hold stable; cmd_valid && cmd_ready -> IDLE the next cycle.
REQ-021 PENDING + execute event without handshake completion: press SHALL be dropped, overrun set to 1, captured data unchanged.
REQ-022 PENDING + handshake completes + execute event same cycle: the new command SHALL be captured; state stays PENDING, no overrun.
REQ-023 Clear event: clear_pulse=1 for exactly one cycle; state -> IDLE; overrun -> 0; cmd_operand/cmd_op -> 0.
REQ-024 Clear and execute events in the same cycle: clear SHALL win and the execute press SHALL be discarded without setting overrun.
REQ-025 Switch changes while PENDING SHALL NOT alter captured outputs.
REQ-026 cmd_ready while IDLE SHALL be ignored.

Reset
REQ-027 While reset_n=0: cmd_valid=0, cmd_operand=0, cmd_op=0, clear_pulse=0, overrun=0, FSM=IDLE, debounce counters=0, stable levels=0, synchronizer flops=0.
REQ-028 A button held during reset release SHALL yield exactly one press event after DEBOUNCE_CYCLES+3 cycles.
REQ-029 Reset assertion mid-debounce or in PENDING SHALL abort immediately with no pulse or handshake emitted afterward until a new qualifying press.

Structure
REQ-030 Shared package panel_pkg SHALL hold the FSM state enum (IDLE, PENDING), DEBOUNCE_CYCLES default, and switch field positions (OPERAND_MSB=15, OPERAND_LSB=8, OP_MSB=3, OP_LSB=0).
REQ-031 One sub-module, debouncer (sync + counter + stable level + press strobe, parameter DEBOUNCE_CYCLES), SHALL be instantiated once per button.
REQ-032 Counter width SHALL be $clog2(DEBOUNCE_CYCLES) bits with no wrap-around reachable.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 sw=16'hA503, btnC held high 20 cycles, cmd_ready=0 -> cmd_valid rises 7 cycles after btnC edge, operand=8'hA5, op=4'h3, held until cmd_ready.
REQ-034 btnC pulses 3 cycles high, 3 low, repeated -> no execute event, cmd_valid stays 0.
REQ-035 PENDING, second clean btnC press, cmd_ready=0 -> overrun=1, operand/op unchanged; btnU press -> clear_pulse one cycle, cmd_valid=0, overrun=0.
REQ-036 btnC and btnU rise same cycle -> clear_pulse once, cmd_valid stays 0, overrun stays 0.
REQ-037 cmd_ready held high from PENDING plus new press on handshake cycle with sw=16'h1F07 -> cmd_valid stays 1, operand=8'h1F, op=4'h7.
REQ-038 reset_n pulsed low in PENDING with btnC held -> outputs 0 immediately; after release exactly one new command 7 cycles later.
